// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and write-port resolution helper
// for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int REG_ZERO   = 0;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_NUM_WR = 8;

  typedef logic [MAX_NUM_WR-1:0]            wen_bus_t;
  typedef logic [MAX_NUM_WR*MAX_ADDR_W-1:0] waddr_bus_t;
  typedef logic [MAX_NUM_WR*MAX_DATA_W-1:0] wdata_bus_t;

  typedef struct packed {
    logic                  hit;
    logic [MAX_DATA_W-1:0] data;
  } wr_pick_t;

  // lowest-index enabled port writing addr wins
  function automatic wr_pick_t wr_pick(
    input wen_bus_t              wen,
    input waddr_bus_t            waddr,
    input wdata_bus_t            wdata,
    input logic [MAX_ADDR_W-1:0] addr
  );
    wr_pick_t p;
    p.hit  = 1'b0;
    p.data = '0;
    for (int j = MAX_NUM_WR - 1; j >= 0; j--) begin
      if (wen[j] &&
          waddr[j*MAX_ADDR_W +: MAX_ADDR_W] == addr) begin
        p.hit  = 1'b1;
        p.data = wdata[j*MAX_DATA_W +: MAX_DATA_W];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with
// claim / release / flush and lookup for held read slots.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_RD*ADDR_W-1:0] cap_addr,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] rel;

  // any enabled write releases its target, winner or not
  always_comb begin
    rel = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j]) rel[waddr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // flush > claim > release > hold; r0 never becomes busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (claim_en && r != REG_ZERO &&
            claim_addr == ADDR_W'(r)) begin
          busy[r] <= 1'b1;
        end else if (rel[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // busy state of the register held in each read slot
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy[i] = busy[cap_addr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with N registered
// read ports, M prioritised write ports, bypass and scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int BYPASS  = 1,
  parameter int RET_REG = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     stall,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  output logic [DATA_W-1:0]        ret_val
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs  [NREG];
  logic [ADDR_W-1:0] ra    [NUM_RD];
  logic [ADDR_W-1:0] cap_q [NUM_RD];
  logic [DATA_W-1:0] rd_q  [NUM_RD];

  wen_bus_t   wen_p;
  waddr_bus_t waddr_p;
  wdata_bus_t wdata_p;

  logic [NREG-1:0]   w_hit;
  logic [DATA_W-1:0] w_val [NREG];
  logic              unused_pick;
  logic [NUM_RD*ADDR_W-1:0] cap_flat;

  // widen write ports into the helper's fixed-size buses
  always_comb begin
    wen_p   = '0;
    waddr_p = '0;
    wdata_p = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wen_p[j] = wen[j];
      waddr_p[j*MAX_ADDR_W +: MAX_ADDR_W] =
        MAX_ADDR_W'(waddr[j*ADDR_W +: ADDR_W]);
      wdata_p[j*MAX_DATA_W +: MAX_DATA_W] =
        MAX_DATA_W'(wdata[j*DATA_W +: DATA_W]);
    end
  end

  // resolved write per register, shared by store and bypass
  always_comb begin
    wr_pick_t p;
    unused_pick = 1'b0;
    w_hit       = '0;
    for (int r = 0; r < NREG; r++) begin
      p = wr_pick(wen_p, waddr_p, wdata_p, MAX_ADDR_W'(r));
      w_hit[r] = p.hit;
      w_val[r] = p.data[DATA_W-1:0];
      unused_pick = unused_pick ^ (^(p.data >> DATA_W));
    end
  end

  // storage; r0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_hit[r]) regs[r] <= w_val[r];
      end
    end
  end

  // unpack read addresses and pack held state for outputs
  always_comb begin
    rdata    = '0;
    cap_flat = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = raddr[i*ADDR_W +: ADDR_W];
      rdata[i*DATA_W +: DATA_W]    = rd_q[i];
      cap_flat[i*ADDR_W +: ADDR_W] = cap_q[i];
    end
  end

  // read capture; stalled slots refresh on a write to the held reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        cap_q[i] <= '0;
        rd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (!stall) begin
          cap_q[i] <= ra[i];
          if (ra[i] == ZERO_A) begin
            rd_q[i] <= '0;
          end else if (BYPASS != 0 && w_hit[ra[i]]) begin
            rd_q[i] <= w_val[ra[i]];
          end else begin
            rd_q[i] <= regs[ra[i]];
          end
        end else if (BYPASS != 0 && cap_q[i] != ZERO_A &&
                     w_hit[cap_q[i]]) begin
          rd_q[i] <= w_val[cap_q[i]];
        end
      end
    end
  end

  assign ret_val = regs[ADDR_W'(RET_REG)];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .wen        (wen),
    .waddr      (waddr),
    .cap_addr   (cap_flat),
    .rbusy      (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random + directed check of regfile_mp,
// BYPASS=1 and BYPASS=0 instances against one reference model.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int NREG = 32;
  localparam int RET  = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             stall;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic             flush;

  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;
  logic [DW-1:0]    ret_b, ret_n;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [DW-1:0] m_regs [NREG];
  logic          m_busy [NREG];
  logic [AW-1:0] m_cap  [NR];
  logic [DW-1:0] m_rd   [2][NR];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b),
    .rbusy(rbusy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
    .stall(stall), .claim_en(claim_en), .claim_addr(claim_addr),
    .flush(flush), .ret_val(ret_b)
  );

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n),
    .rbusy(rbusy_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .stall(stall), .claim_en(claim_en), .claim_addr(claim_addr),
    .flush(flush), .ret_val(ret_n)
  );

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      m_cap[i]   = '0;
      m_rd[0][i] = '0;
      m_rd[1][i] = '0;
    end
  endtask

  // one clock edge of the architectural behaviour
  task automatic model_step();
    logic          whit [NREG];
    logic [DW-1:0] wval [NREG];
    int a;
    for (int r = 0; r < NREG; r++) begin
      whit[r] = 1'b0;
      wval[r] = '0;
    end
    for (int j = 0; j < NW; j++) begin
      a = int'(waddr[j*AW +: AW]);
      if (wen[j] && a != 0 && !whit[a]) begin
        whit[a] = 1'b1;
        wval[a] = wdata[j*DW +: DW];
      end
    end
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NR; i++) begin
        if (!stall) begin
          a = int'(raddr[i*AW +: AW]);
          if (a == 0)                m_rd[v][i] = '0;
          else if (v == 1 && whit[a]) m_rd[v][i] = wval[a];
          else                       m_rd[v][i] = m_regs[a];
        end else if (v == 1 && m_cap[i] != 0 && whit[m_cap[i]]) begin
          m_rd[v][i] = wval[m_cap[i]];
        end
      end
    end
    if (!stall) begin
      for (int i = 0; i < NR; i++) m_cap[i] = raddr[i*AW +: AW];
    end
    for (int r = 0; r < NREG; r++) begin
      if (flush) begin
        m_busy[r] = 1'b0;
      end else if (claim_en && r != 0 && int'(claim_addr) == r) begin
        m_busy[r] = 1'b1;
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (wen[j] && int'(waddr[j*AW +: AW]) == r) m_busy[r] = 1'b0;
        end
      end
    end
    for (int r = 1; r < NREG; r++) begin
      if (whit[r]) m_regs[r] = wval[r];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("byp_rdata%0d", i), rdata_b[i*DW +: DW], m_rd[1][i]);
      check($sformatf("nob_rdata%0d", i), rdata_n[i*DW +: DW], m_rd[0][i]);
      check($sformatf("byp_rbusy%0d", i), 32'(rbusy_b[i]), 32'(m_busy[m_cap[i]]));
      check($sformatf("nob_rbusy%0d", i), 32'(rbusy_n[i]), 32'(m_busy[m_cap[i]]));
    end
    check("byp_ret", ret_b, m_regs[RET]);
    check("nob_ret", ret_n, m_regs[RET]);
  endtask

  task automatic idle();
    raddr = '0; wen = '0; waddr = '0; wdata = '0;
    stall = 1'b0; claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_rdata0", rdata_b[DW-1:0], 32'h0);
    check("rst_ret", ret_b, 32'h0);
    check("rst_rbusy", 32'(rbusy_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    check("init_rdata", rdata_b[DW-1:0], 32'h0);
    check("init_ret", ret_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // write and read r5, then reset mid-operation
    idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); cycle();
    check("nob_old_r5", rdata_n[DW-1:0], 32'h0);
    idle(); set_rd(0, 5); claim_en = 1'b1; claim_addr = 5; cycle();
    check("read_r5", rdata_b[DW-1:0], 32'hDEADBEEF);
    pulse_reset();
    idle(); set_rd(0, 5); cycle();
    check("r5_after_rst", rdata_b[DW-1:0], 32'h0);

    // write priority
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); cycle();
    idle(); set_rd(0, 7); cycle();
    check("prio_r7", rdata_b[DW-1:0], 32'h11);

    // same-cycle bypass
    idle(); set_wr(0, 9, 32'hCAFE0009); set_rd(0, 9); cycle();
    check("bypass_r9", rdata_b[DW-1:0], 32'hCAFE0009);
    check("nobypass_r9", rdata_n[DW-1:0], 32'h0);

    // stall refresh
    idle(); set_wr(0, 4, 32'h1); cycle();
    idle(); set_rd(0, 4); cycle();
    idle(); stall = 1'b1; set_rd(0, 6); set_wr(0, 4, 32'h44); cycle();
    check("stall_refresh", rdata_b[DW-1:0], 32'h44);
    check("stall_stale", rdata_n[DW-1:0], 32'h1);
    idle(); stall = 1'b1; set_rd(0, 6); set_wr(1, 0, 32'h99); cycle();
    check("stall_r0_write", rdata_b[DW-1:0], 32'h44);

    // scoreboard and ret_val
    idle(); set_rd(1, 3); claim_en = 1'b1; claim_addr = 3; cycle();
    check("claim_r3", 32'(rbusy_b[1]), 32'h1);
    idle(); set_rd(1, 3); set_wr(1, 3, 32'h2A); cycle();
    check("release_r3", 32'(rbusy_b[1]), 32'h0);
    check("ret_2a", ret_b, 32'h2A);
    idle(); set_rd(1, 3); set_wr(0, 3, 32'h5); claim_en = 1'b1;
    claim_addr = 3; cycle();
    check("claim_beats_write", 32'(rbusy_b[1]), 32'h1);
    idle(); set_rd(1, 3); flush = 1'b1; claim_en = 1'b1;
    claim_addr = 3; cycle();
    check("flush", 32'(rbusy_b[1]), 32'h0);
    idle(); claim_en = 1'b1; claim_addr = 0; cycle();
    check("claim_r0", 32'(rbusy_b[1]), 32'h0);
    idle(); set_wr(0, 0, 32'hFFFF); set_rd(0, 0); set_rd(1, 0); cycle();
    idle(); set_rd(0, 0); cycle();
    check("read_r0", rdata_b[DW-1:0], 32'h0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(63) == 0) begin
        pulse_reset();
      end else begin
        idle();
        for (int i = 0; i < NR; i++) set_rd(i, int'($urandom_range(7)));
        for (int j = 0; j < NW; j++) begin
          if ($urandom_range(1) == 1) set_wr(j, int'($urandom_range(7)), $urandom);
        end
        stall      = ($urandom_range(3) == 0);
        claim_en   = ($urandom_range(2) == 0);
        claim_addr = AW'($urandom_range(7));
        flush      = ($urandom_range(15) == 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the integer register file.
- Configurable data and address width, N registered read ports and M prioritised write ports.
- Write-to-read bypass, including refresh of held read data during stall.
- Per-register busy scoreboard for load-use and multi-cycle producers.
- Sits between decode (reads, claims) and writeback (writes); exposes the return-value register for test.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; 2**ADDR_W registers; register 0 hardwired to zero.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; lower index has higher priority.
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding and stall refresh; 0 disables both.
- RET_REG, 3, index exposed on ret_val.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at slice i.
- rdata  out  NUM_RD*DATA_W  registered read data.
- rbusy  out  NUM_RD  busy bit of the register currently held on each rdata slot.
- wen  in  NUM_WR  write enables.
- waddr  in  NUM_WR*ADDR_W  write addresses.
- wdata  in  NUM_WR*DATA_W  write data.
- stall  in  1  hold read outputs and captured addresses.
- claim_en  in  1  mark claim_addr busy (producer issued).
- claim_addr  in  ADDR_W  register to mark busy.
- flush  in  1  clear entire scoreboard.
- ret_val  out  DATA_W  combinational copy of register RET_REG.

Behaviour:
- Reset (async, any time, including mid-stall): all registers, rdata, captured read addresses and busy bits go to 0, so rbusy=0 and ret_val=0. First capture occurs on the first rising edge after rst deasserts.
- Write resolution:
  - For each register r, the lowest-index j with wen[j] and waddr[j]==r wins; higher-index writes to the same r are dropped.
  - Writes to address 0 are ignored.
  - Writes are never blocked by stall.
- Read, stall=0: on the edge, cap_addr[i] <= raddr[i] and rdata[i] is loaded as follows.
  - raddr[i]==0: 0.
  - Else, BYPASS=1 and a write to raddr[i] this cycle: the winning wdata.
  - Else: the stored register value.
- Read latency is 1 cycle.
- Read, stall=1: cap_addr and rdata hold.
  - Exception (BYPASS=1 only): if a write this cycle targets cap_addr[i]!=0, rdata[i] <= the winning wdata, so held operands never go stale.
  - With BYPASS=0, held data stays stale (legacy behaviour).
- Scoreboard: busy[0] is constant 0. Per register r, in priority order:
  - flush: busy <= 0.
  - Else claim_en and claim_addr==r and r!=0: busy <= 1. A claim beats a same-cycle write, since a new producer supersedes the old one.
  - Else any wen[j] with waddr[j]==r: busy <= 0.
  - Else hold.
- rbusy[i] = busy[cap_addr[i]], combinational from registered state. It reflects the post-edge scoreboard, so a release write at edge k shows rbusy=0 after edge k.
- ret_val = regs[RET_REG], combinational, post-write value.
- Arithmetic: none. Unsigned equality compares only; no wrap cases beyond address-0 handling.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W/NUM_RD/NUM_WR and the REG_ZERO constant.
- Function in the package returning the winning write data and hit flag for a given address, used by both the write and bypass paths.
- Sub-module regfile_scoreboard (busy vector, claim/flush/release logic, rbusy lookup); storage and read ports stay in regfile_mp.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, read r5; assert rst for 1 cycle → rdata=0, ret_val=0, rbusy=0; after release, reading r5 returns 0.
- Write priority: wen=2'b11, waddr both 7, wdata0=0x11, wdata1=0x22 → read r7 next cycle returns 0x11.
- Same-cycle bypass: raddr0=9 while wen0 writes 0xCAFE0009 to r9 → rdata0=0xCAFE0009 one cycle later. BYPASS=0 variant returns the old value.
- Stall refresh: capture r4 (old 0x1), hold stall=1, write 0x44 to r4 → rdata=0x44 while still stalled. A write to r0 or a write during stall with raddr changed to r6 leaves cap_addr and rdata unaffected by raddr.
- Scoreboard:
  - claim r3 → rbusy=1 on the port holding r3, then write r3 → rbusy=0.
  - Claim and write r3 same cycle → busy stays 1.
  - flush with claim_en → all busy 0.
  - Claim r0 → rbusy stays 0.
- ret_val: write 0x2A to r3 via wen1 → ret_val=0x2A immediately after the edge; write to r0 → all reads of r0 return 0.
